// File: rtl/vco_spi_master.sv
// vco_spi_master
// SPI initiator for the VCO/PLL synthesizer. The host writes 32-bit PLL
// register words to one settings-bus address. Words are queued in a small
// FIFO and shifted out MSB-first. Each word is then latched into the PLL
// with a load-enable (LE) pulse. The block also brings the asynchronous
// MUXOUT lock-detect pin into the clock domain and keeps sticky status flags.
//
// Ports
//   clock          system clock (settings-bus domain)
//   reset_n        asynchronous active-low reset
//   serial_addr    settings-bus address
//   serial_data    settings-bus write data
//   serial_strobe  settings-bus write strobe, one cycle wide
//   clear_status   clears overflow and lock_lost
//   vco_muxout     PLL MUXOUT lock-detect pin, asynchronous
//   vco_sclk       SPI clock to the PLL; idles low, the PLL samples on the rising edge
//   vco_sdata      SPI data to the PLL
//   vco_le         PLL load enable, active high
//   busy           FIFO non-empty or a word in flight
//   fifo_level     number of words queued, not counting the word being shifted
//   overflow       sticky: a word was dropped because the FIFO was full
//   locked         synchronized vco_muxout
//   lock_lost      sticky: locked fell from 1 to 0
module vco_spi_master #(
    parameter logic [6:0] ADDR      = 7'd72,
    parameter int         CLKDIV    = 4,
    parameter int         LE_CYCLES = 8,
    parameter int         FIFO_LOG2 = 3
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [6:0]           serial_addr,
    input  logic [31:0]          serial_data,
    input  logic                 serial_strobe,
    input  logic                 clear_status,
    input  logic                 vco_muxout,
    output logic                 vco_sclk,
    output logic                 vco_sdata,
    output logic                 vco_le,
    output logic                 busy,
    output logic [FIFO_LOG2:0]   fifo_level,
    output logic                 overflow,
    output logic                 locked,
    output logic                 lock_lost
);

    localparam int DEPTH   = 2 ** FIFO_LOG2;
    localparam int CNT_MAX = (CLKDIV > LE_CYCLES) ? CLKDIV : LE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]   DIV_LAST   = CNT_W'(CLKDIV - 1);
    localparam logic [CNT_W-1:0]   LE_LAST    = CNT_W'(LE_CYCLES - 1);
    localparam logic [FIFO_LOG2:0] FULL_LEVEL = (FIFO_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        LE_SETUP,
        LE_PULSE,
        GAP
    } state_t;

    logic [31:0]          fifo_mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr;
    logic [FIFO_LOG2-1:0] rd_ptr;
    logic                 push_req;
    logic                 push_ok;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 phase_high, phase_n;
    logic [4:0]           bit_cnt, bit_n;
    logic                 last_low, last_n;
    logic [31:0]          shift_reg, shift_n;
    logic                 cnt_done;
    logic                 le_done;

    logic                 sync_meta;
    logic                 lock_fall;

    // Fullness is judged on the level at the start of the cycle, so a pop in
    // the same cycle cannot make room for a push into a full FIFO.
    assign push_req   = serial_strobe && (serial_addr == ADDR);
    assign fifo_full  = (fifo_level == FULL_LEVEL);
    assign fifo_empty = (fifo_level == '0);
    assign push_ok    = push_req && !fifo_full;
    assign busy       = (state != IDLE) || !fifo_empty;
    assign cnt_done   = (cnt == DIV_LAST);
    assign le_done    = (cnt == LE_LAST);

    // The storage array has no reset; the pointers and the level define which
    // entries are valid.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= serial_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // LOAD holds bit 31 with sclk low for CLKDIV cycles; this is the low phase
    // of the first bit. SHIFT then runs each bit as a high phase followed by a
    // low phase. Data moves to the next bit at the start of a low phase. The
    // low phase after bit 0 holds the last bit, and last_low marks it.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        phase_n = phase_high;
        bit_n   = bit_cnt;
        last_n  = last_low;
        shift_n = shift_reg;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_mem[rd_ptr];
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (cnt_done) begin
                    cnt_n   = '0;
                    phase_n = 1'b1;
                    bit_n   = 5'd31;
                    last_n  = 1'b0;
                    state_n = SHIFT;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (!cnt_done) begin
                    cnt_n = cnt + 1'b1;
                end else begin
                    cnt_n = '0;
                    if (phase_high) begin
                        phase_n = 1'b0;
                        if (bit_cnt != 5'd0) begin
                            bit_n   = bit_cnt - 1'b1;
                            shift_n = {shift_reg[30:0], 1'b0};
                        end else begin
                            last_n = 1'b1;
                        end
                    end else if (last_low) begin
                        state_n = LE_SETUP;
                    end else begin
                        phase_n = 1'b1;
                    end
                end
            end
            LE_SETUP: begin
                if (cnt_done) begin
                    cnt_n   = '0;
                    state_n = LE_PULSE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            LE_PULSE: begin
                if (le_done) begin
                    cnt_n   = '0;
                    state_n = GAP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt_done) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // The pins are registered from the next-state values. They stay glitch-free
    // toward the PLL and keep the same cycle timing as the FSM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            phase_high <= 1'b0;
            bit_cnt    <= 5'd0;
            last_low   <= 1'b0;
            shift_reg  <= '0;
            vco_sclk   <= 1'b0;
            vco_sdata  <= 1'b0;
            vco_le     <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            phase_high <= phase_n;
            bit_cnt    <= bit_n;
            last_low   <= last_n;
            shift_reg  <= shift_n;
            vco_sclk   <= (state_n == SHIFT) && phase_n;
            vco_sdata  <= ((state_n == LOAD) || (state_n == SHIFT)) ? shift_n[31] : 1'b0;
            vco_le     <= (state_n == LE_PULSE);
        end
    end

    // lock_fall is detected one stage early, so lock_lost rises in the same
    // cycle that locked drops. A set wins over a same-cycle clear.
    assign lock_fall = locked && !sync_meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            locked    <= 1'b0;
            lock_lost <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            sync_meta <= vco_muxout;
            locked    <= sync_meta;
            if (lock_fall) begin
                lock_lost <= 1'b1;
            end else if (clear_status) begin
                lock_lost <= 1'b0;
            end
            if (push_req && fifo_full) begin
                overflow <= 1'b1;
            end else if (clear_status) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
